ddr_rx_aligner: RTL and testbench

- Consumes the rising/falling half-word pairs produced by the DDR demultiplexer.
- Runs a training state machine that locks onto a known training word and resolves which edge carries the first half-word.
- Once locked, emits aligned full-width words at single data rate.
- Sits directly after the DDR demultiplexer in every DDR receive path; the link-management FSM sequences it via enable/relock.

---
 rtl/ddr_rx_aligner.sv | 181 ++++++++++++++++++
 tb/tb_ddr_rx_aligner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rx_aligner.sv
// ddr_rx_aligner
// Aligns the rising/falling half-word pairs coming out of the DDR demux into
// full-width words. A training FSM hunts for train_word in either phase:
// A = {falling, rising} (falling edge first in time) or
// B = {previous rising, falling} (rising edge first in time).
// Once the pattern has been seen lock_count times in a row, the selected
// phase is used to emit one aligned word per pair.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   enable, relock        sequencing from the link-management FSM
//   rising_valid/rising   rising-edge half-word from the demux
//   falling_valid/falling falling-edge half-word from the demux
//   dout_valid, dout      aligned word, one-cycle strobe, latency 1
//   locked, swap          lock status and selected phase (1 = rising-first)
//   err_count             saturating half-pair error count while locked
//
// state  | meaning
// IDLE   | disabled, outputs quiescent, stale rising half discarded
// HUNT   | searching both phases for the training word
// VERIFY | phase chosen, counting consecutive training words
// LOCKED | emitting aligned words, counting half-pair errors
module ddr_rx_aligner #(
    parameter int                  width      = 8,
    parameter logic [2*width-1:0]  train_word = 16'h5AA5,
    parameter int                  lock_count = 4,
    parameter int                  err_limit  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 relock,
    input  logic                 rising_valid,
    input  logic [width-1:0]     rising,
    input  logic                 falling_valid,
    input  logic [width-1:0]     falling,
    output logic                 dout_valid,
    output logic [2*width-1:0]   dout,
    output logic                 locked,
    output logic                 swap,
    output logic [7:0]           err_count
);

    typedef enum logic [1:0] {IDLE, HUNT, VERIFY, LOCKED} state_t;

    localparam logic [3:0] lock_cnt_c = 4'(lock_count);
    localparam logic [7:0] err_lim_c  = 8'(err_limit);

    state_t              state_q, state_d;
    logic [3:0]          count_q, count_d;
    logic                swap_q, swap_d;
    logic                locked_q, locked_d;
    logic [width-1:0]    rising_q, rising_d;
    logic                rq_valid_q, rq_valid_d;
    logic [2*width-1:0]  dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic [7:0]          err_count_q, err_count_d;

    logic                pair;
    logic                half_pair;
    logic [2*width-1:0]  cand_a;
    logic [2*width-1:0]  cand_b;
    logic [2*width-1:0]  selected;
    logic [3:0]          count_inc;
    logic [7:0]          err_inc;

    always_comb begin
        pair      = rising_valid & falling_valid;
        half_pair = rising_valid ^ falling_valid;
        cand_a    = {falling, rising};
        cand_b    = {rising_q, falling};
        selected  = swap_q ? cand_b : cand_a;
        count_inc = count_q + 4'd1;
        err_inc   = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

        state_d      = state_q;
        count_d      = count_q;
        swap_d       = swap_q;
        rising_d     = rising_q;
        rq_valid_d   = rq_valid_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        err_count_d  = err_count_q;

        // The previous rising half is tracked on every pair while active,
        // including relock and error cycles, so B is ready right away.
        if (enable && state_q != IDLE && pair) begin
            rising_d   = rising;
            rq_valid_d = 1'b1;
        end

        if (!enable) begin
            state_d    = IDLE;
            count_d    = 4'd0;
            rq_valid_d = 1'b0;
        end else if (relock && (state_q == VERIFY || state_q == LOCKED)) begin
            state_d = HUNT;
            count_d = 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rq_valid_d = 1'b0;
                    state_d    = HUNT;
                end
                HUNT: begin
                    if (pair) begin
                        if (cand_a == train_word) begin
                            swap_d  = 1'b0;
                            count_d = 4'd1;
                            state_d = VERIFY;
                        end else if (rq_valid_q && cand_b == train_word) begin
                            swap_d  = 1'b1;
                            count_d = 4'd1;
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (pair) begin
                        if (selected == train_word) begin
                            count_d = count_inc;
                            if (count_inc >= lock_cnt_c) begin
                                state_d     = LOCKED;
                                err_count_d = 8'd0;
                            end
                        end else begin
                            count_d = 4'd0;
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (half_pair) begin
                        err_count_d = err_inc;
                        if (err_inc == err_lim_c) begin
                            state_d = HUNT;
                            count_d = 4'd0;
                        end
                    end else if (pair) begin
                        dout_d       = selected;
                        dout_valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= 4'd0;
            swap_q       <= 1'b0;
            locked_q     <= 1'b0;
            rising_q     <= '0;
            rq_valid_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            swap_q       <= swap_d;
            locked_q     <= locked_d;
            rising_q     <= rising_d;
            rq_valid_q   <= rq_valid_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            err_count_q  <= err_count_d;
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign locked     = locked_q;
    assign swap       = swap_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_ddr_rx_aligner.sv
// Self-checking bench for ddr_rx_aligner: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the aligner's rules.
module tb_ddr_rx_aligner;

    localparam logic [15:0] tw      = 16'h5AA5;
    localparam int          lock_n  = 4;
    localparam int          err_lim = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        relock = 1'b0;
    logic        rising_valid = 1'b0;
    logic        falling_valid = 1'b0;
    logic [7:0]  rising = 8'h00;
    logic [7:0]  falling = 8'h00;
    logic        dout_valid;
    logic [15:0] dout;
    logic        locked;
    logic        swap;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    // model: mode 0 = off, 1 = searching, 2 = confirming, 3 = aligned
    int          m_mode;
    int          m_hits;
    int          m_err;
    bit          m_prev_ok;
    logic [7:0]  m_prev;
    bit          m_swap;
    logic [15:0] m_dout;
    bit          m_dv;

    ddr_rx_aligner #(
        .width(8), .train_word(16'h5AA5), .lock_count(lock_n), .err_limit(err_lim)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .relock(relock),
        .rising_valid(rising_valid), .rising(rising),
        .falling_valid(falling_valid), .falling(falling),
        .dout_valid(dout_valid), .dout(dout), .locked(locked),
        .swap(swap), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_mode = 0; m_hits = 0; m_err = 0; m_prev_ok = 0; m_prev = 8'h00;
        m_swap = 0; m_dout = 16'h0000; m_dv = 0;
    endtask

    task automatic model_edge(input bit en, input bit rl, input bit rv, input bit fv,
                              input logic [7:0] f, input logic [7:0] r);
        bit          is_pair = rv && fv;
        bit          is_half = (rv != fv);
        bit          old_ok  = m_prev_ok;
        logic [15:0] word_a  = {f, r};
        logic [15:0] word_b  = {m_prev, f};
        logic [15:0] word_s  = m_swap ? word_b : word_a;
        m_dv = 0;
        if (!en) begin
            m_mode = 0; m_hits = 0; m_prev_ok = 0;
            return;
        end
        if (m_mode == 0) begin
            m_mode = 1; m_prev_ok = 0;
            return;
        end
        if (is_pair) begin
            m_prev = r; m_prev_ok = 1;
        end
        if (rl && m_mode >= 2) begin
            m_mode = 1; m_hits = 0;
            return;
        end
        if (m_mode == 1) begin
            if (is_pair && word_a == tw) begin
                m_swap = 0; m_hits = 1; m_mode = 2;
            end else if (is_pair && old_ok && word_b == tw) begin
                m_swap = 1; m_hits = 1; m_mode = 2;
            end
        end else if (m_mode == 2) begin
            if (is_pair) begin
                if (word_s == tw) begin
                    m_hits++;
                    if (m_hits >= lock_n) begin
                        m_mode = 3; m_err = 0;
                    end
                end else begin
                    m_mode = 1; m_hits = 0;
                end
            end
        end else begin
            if (is_half) begin
                m_err = (m_err < 255) ? m_err + 1 : 255;
                if (m_err == err_lim) begin
                    m_mode = 1; m_hits = 0;
                end
            end else if (is_pair) begin
                m_dout = word_s; m_dv = 1;
            end
        end
    endtask

    task automatic step(input bit en, input bit rl, input bit rv, input bit fv,
                        input logic [7:0] f, input logic [7:0] r);
        enable = en; relock = rl; rising_valid = rv; falling_valid = fv;
        falling = f; rising = r;
        @(posedge clock);
        model_edge(en, rl, rv, fv, f, r);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; relock = 0; rising_valid = 0; falling_valid = 0;
        @(posedge clock);
        model_reset();
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %0b want 0", dout_valid); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h want 0000", dout); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", locked); end
        checks++; if (swap !== 1'b0) begin errors++; $display("FAIL reset_swap: got %0b want 0", swap); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_count); end
    endtask

    task automatic test_lock_a();
        step(1, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 1, 1, 8'h5A, 8'hA5);
            checks++;
            if (locked !== (i == 4)) begin errors++; $display("FAIL lock_a_locked pair %0d: got %0b want %0b", i, locked, (i == 4)); end
        end
        checks++; if (swap !== 1'b0) begin errors++; $display("FAIL lock_a_swap: got %0b want 0", swap); end
        step(1, 0, 1, 1, 8'h12, 8'h34);
        checks++; if (dout_valid !== 1'b1 || dout !== 16'h1234) begin errors++; $display("FAIL lock_a_data: got %0b/%h want 1/1234", dout_valid, dout); end
        step(1, 0, 0, 0, 8'h00, 8'h00);
        checks++; if (dout_valid !== 1'b0 || dout !== 16'h1234) begin errors++; $display("FAIL lock_a_hold: got %0b/%h want 0/1234", dout_valid, dout); end
    endtask

    task automatic test_err_limit();
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 1, 0, 8'h5A, 8'hA5);
            checks++; if (err_count !== 8'(i)) begin errors++; $display("FAIL err_count %0d: got %0d want %0d", i, err_count, i); end
            checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL err_dv %0d: got %0b want 0", i, dout_valid); end
            checks++; if (locked !== (i < 3)) begin errors++; $display("FAIL err_locked %0d: got %0b want %0b", i, locked, (i < 3)); end
            step(1, 0, 0, 0, 8'h00, 8'h00);
        end
    endtask

    task automatic test_verify_fail();
        do_reset();
        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(1, 0, 1, 1, 8'h5A, 8'hA5);
        step(1, 0, 1, 1, 8'h5A, 8'hA5);
        step(1, 0, 1, 1, 8'h5A, 8'hA6);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL vfail_locked: got %0b want 0", locked); end
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 1, 1, 8'h5A, 8'hA5);
            checks++;
            if (locked !== (i == 4)) begin errors++; $display("FAIL vfail_relock pair %0d: got %0b want %0b", i, locked, (i == 4)); end
        end
    endtask

    task automatic test_lock_b();
        logic [7:0] fall_seq [5] = '{8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        do_reset();
        step(1, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 1, fall_seq[i], 8'h5A);
            checks++;
            if (locked !== (i == 4)) begin errors++; $display("FAIL lock_b_locked pair %0d: got %0b want %0b", i + 1, locked, (i == 4)); end
        end
        checks++; if (swap !== 1'b1) begin errors++; $display("FAIL lock_b_swap: got %0b want 1", swap); end
        step(1, 0, 1, 1, 8'h11, 8'h22);
        checks++; if (dout_valid !== 1'b1 || dout !== 16'h5A11) begin errors++; $display("FAIL lock_b_w1: got %0b/%h want 1/5a11", dout_valid, dout); end
        step(1, 0, 1, 1, 8'h33, 8'h44);
        checks++; if (dout_valid !== 1'b1 || dout !== 16'h2233) begin errors++; $display("FAIL lock_b_w2: got %0b/%h want 1/2233", dout_valid, dout); end
    endtask

    task automatic test_enable_drop();
        step(1, 0, 1, 1, 8'h77, 8'h5A);
        step(0, 1, 1, 1, 8'h00, 8'h00);
        checks++; if (locked !== 1'b0 || dout_valid !== 1'b0) begin errors++; $display("FAIL endrop_out: got %0b/%0b want 0/0", locked, dout_valid); end
        step(1, 0, 0, 0, 8'h00, 8'h00);
        // would be a B match if the stale rising half survived the disable
        step(1, 0, 1, 1, 8'hA5, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 1, 1, 8'h5A, 8'hA5);
            checks++;
            if (locked !== (i == 4)) begin errors++; $display("FAIL endrop_locked pair %0d: got %0b want %0b", i, locked, (i == 4)); end
        end
        checks++; if (swap !== 1'b0) begin errors++; $display("FAIL endrop_swap: got %0b want 0", swap); end
    endtask

    task automatic test_relock();
        step(1, 1, 1, 1, 8'h12, 8'h34);
        checks++; if (dout_valid !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL relock_out: got %0b/%0b want 0/0", dout_valid, locked); end
        step(1, 0, 1, 1, 8'h56, 8'h78);
        checks++; if (dout_valid !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL relock_hunt: got %0b/%0b want 0/0", dout_valid, locked); end
    endtask

    task automatic test_random_data();
        int sel;
        do_reset();
        step(1, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 8'h5A, 8'hA5);
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 19);
            step(1, 0, sel < 17 || sel == 19, sel < 17 || sel == 18,
                 8'($urandom), 8'($urandom));
            checks++;
            if (dout_valid !== m_dv || (m_dv && dout !== m_dout)) begin
                errors++; $display("FAIL rdata cycle %0d: got %0b/%h want %0b/%h", i, dout_valid, dout, m_dv, m_dout);
            end
            checks++;
            if (locked !== (m_mode == 3) || err_count !== 8'(m_err)) begin
                errors++; $display("FAIL rdata_status cycle %0d: got %0b/%0d want %0b/%0d", i, locked, err_count, (m_mode == 3), m_err);
            end
        end
    endtask

    function automatic logic [7:0] pick_half();
        int k = $urandom_range(0, 9);
        if (k < 4) return 8'h5A;
        if (k < 8) return 8'hA5;
        return 8'($urandom);
    endfunction

    task automatic test_stress();
        int  vsel;
        bit  en, rl;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            en   = ($urandom_range(0, 79) != 0);
            rl   = ($urandom_range(0, 69) == 0);
            vsel = $urandom_range(0, 15);
            step(en, rl, vsel < 12 || vsel == 14, vsel < 12 || vsel == 15,
                 pick_half(), pick_half());
            checks++;
            if (dout_valid !== m_dv || dout !== m_dout) begin
                errors++; $display("FAIL stress_data cycle %0d: got %0b/%h want %0b/%h", i, dout_valid, dout, m_dv, m_dout);
            end
            checks++;
            if (locked !== (m_mode == 3) || swap !== m_swap || err_count !== 8'(m_err)) begin
                errors++; $display("FAIL stress_status cycle %0d: got %0b/%0b/%0d want %0b/%0b/%0d",
                                   i, locked, swap, err_count, (m_mode == 3), m_swap, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock_a();
        test_err_limit();
        test_verify_fail();
        test_lock_b();
        test_enable_drop();
        test_relock();
        test_random_data();
        test_stress();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
